prom_boot_loader: RTL and testbench
===================================

// Module: prom_boot_loader
// PURPOSE
//  Boot-time copier between the 512x32 boot PROM and main RAM. Drives the
//  PROM word address, captures each registered PROM word (1-cycle read
//  latency) and writes it to RAM over a req/ack write port. Holds the CPU
//  in reset until the image is in RAM, then releases it and reports a
//  32-bit additive checksum of the copied image.
// PARAMETERS
//  WORDS     512      words to copy, 1..512; PROM addresses 0..WORDS-1
//  RAM_AW    18       RAM word-address width
//  DST_BASE  0        RAM word address receiving PROM word 0
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse: begin copy (honoured in IDLE/DONE)
//  prom_adr   out  9       PROM word address
//  prom_data  in   32      PROM word, valid 1 cycle after prom_adr
//  ram_adr    out  RAM_AW  RAM word address of current write
//  ram_wdata  out  32      RAM write data
//  ram_we     out  1       write request; held until ram_ack
//  ram_ack    in   1       RAM accepted the write this cycle
//  busy       out  1       copy in progress
//  done       out  1       sticky: image copied; cleared by start or rst
//  cpu_hold   out  1       1 = keep CPU in reset; 0 only when done
//  checksum   out  32      sum mod 2^32 of all words written this copy
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, prom_adr=0, ram_adr=DST_BASE, ram_wdata=0,
//   ram_we=0, busy=0, done=0, cpu_hold=1, checksum=0.
//  prom_adr = cnt[8:0]; ram_adr = DST_BASE + cnt (mod 2^RAM_AW).
//  FSM (state register; all outputs registered or decoded from state):
//   IDLE : start -> FETCH, cnt=0, checksum=0, busy=1.
//   FETCH: one cycle for PROM latency -> LATCH.
//   LATCH: ram_wdata <= prom_data; ram_we <= 1 -> WRITE.
//   WRITE: hold ram_we/ram_adr/ram_wdata stable until ram_ack.
//          On ack: ram_we<=0, checksum += ram_wdata;
//          cnt==WORDS-1 -> DONE, else cnt++ -> FETCH.
//   DONE : busy=0, done=1, cpu_hold=0; start -> FETCH as from IDLE
//          (done<=0, cpu_hold<=1 on the same edge).
//  Throughput: 3 cycles/word with zero-wait ack (FETCH, LATCH, WRITE).
//  ram_ack is ignored outside WRITE; ack in the same cycle ram_we rises
//   counts only if ram_we is already 1 (ack sampled in WRITE only).
//  start while busy is ignored. cnt never exceeds WORDS-1; no wrap.
//  rst mid-copy: next edge returns to reset values; ram_we drops at once,
//   the in-flight write is abandoned, cpu_hold reasserts.
//  Checksum covers only acknowledged words.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/FETCH/LATCH/WRITE/DONE),
//   PROM_WORDS=512, PROM_AW=9.
//  Single module, no sub-modules; instantiated beside PROM in the top
//   level with prom_adr -> PROM adr, PROM data -> prom_data.
// TESTING
//  1 Reset then idle 10 cycles -> ram_we=0, busy=0, cpu_hold=1, done=0.
//  2 WORDS=4, PROM[i]=i+0x100, ack tied 1, start -> writes 0x100..0x103 at
//    DST_BASE..+3, done after 12 cycles, checksum=0x406, cpu_hold=0.
//  3 Ack delayed 5 cycles on word 1 -> ram_we/adr/wdata stable throughout,
//    no duplicate or skipped write, final checksum unchanged.
//  4 Full 512-word copy, PROM[i]=0xFFFFFFFF -> 512 writes, last ram_adr=
//    DST_BASE+511, checksum=0xFFFFFE00 (mod 2^32 wrap).
//  5 rst asserted during WRITE of word 2 -> next cycle ram_we=0, all outputs
//    at reset values; new start recopies from word 0.
//  6 start pulsed while busy -> ignored; start in DONE -> done drops,
//    cpu_hold=1, second copy identical to first.

Source files
------------

// File: rtl/prom_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// prom_boot_loader_pkg
// Shared definitions for the boot PROM -> RAM copier: PROM geometry and the
// copier FSM state encoding.
// ----------------------------------------------------------------------------
package prom_boot_loader_pkg;

    localparam int PROM_WORDS = 512;
    localparam int PROM_AW    = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/prom_boot_loader.sv
// ----------------------------------------------------------------------------
// prom_boot_loader
// Boot-time copier from the 512x32 boot PROM into main RAM. Each word takes
// three states: FETCH (PROM address presented, PROM registers it), LATCH
// (PROM word captured into the write-data register) and WRITE (request held
// until the RAM acknowledges). The CPU is kept in reset until the whole image
// is in RAM; an additive 32-bit checksum of the acknowledged words is kept.
//
// Ports
//   clk        in   1       system clock, posedge
//   rst        in   1       synchronous active-high reset
//   start      in   1       pulse: begin a copy (honoured in IDLE and DONE)
//   prom_adr   out  9       PROM word address
//   prom_data  in   32      PROM word, valid one cycle after prom_adr
//   ram_adr    out  RAM_AW  RAM word address of the current write
//   ram_wdata  out  32      RAM write data
//   ram_we     out  1       write request, held until ram_ack
//   ram_ack    in   1       RAM accepted the write this cycle
//   busy       out  1       copy in progress
//   done       out  1       image copied (sticky until start or rst)
//   cpu_hold   out  1       1 keeps the CPU in reset; 0 only when done
//   checksum   out  32      sum mod 2^32 of the words written this copy
// ----------------------------------------------------------------------------
module prom_boot_loader
    import prom_boot_loader_pkg::*;
#(
    parameter int WORDS    = 512,
    parameter int RAM_AW   = 18,
    parameter int DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [8:0]        prom_adr,
    input  logic [31:0]       prom_data,
    output logic [RAM_AW-1:0] ram_adr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic              ram_ack,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [31:0]       checksum
);

    localparam logic [PROM_AW-1:0] LAST_CNT = PROM_AW'(WORDS - 1);
    localparam logic [RAM_AW-1:0]  DST      = RAM_AW'(DST_BASE);

    state_t             state, state_nxt;
    logic [PROM_AW-1:0] cnt, cnt_nxt;
    logic [31:0]        wdata, wdata_nxt;
    logic [31:0]        sum, sum_nxt;

    // State register: control and data alike come back to known values on rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wdata <= '0;
            sum   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wdata <= wdata_nxt;
            sum   <= sum_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wdata_nxt = wdata;
        sum_nxt   = sum;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    cnt_nxt   = '0;
                    sum_nxt   = '0;
                end
            end
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: begin
                wdata_nxt = prom_data;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // ack only matters while the request is already up, i.e. here
                if (ram_ack) begin
                    sum_nxt = sum + wdata;
                    if (cnt == LAST_CNT) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt   = cnt + PROM_AW'(1);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: registers or pure state decodes, so no combinational paths
    // from inputs to outputs
    assign prom_adr  = cnt;
    assign ram_adr   = DST + RAM_AW'(cnt);
    assign ram_wdata = wdata;
    assign ram_we    = (state == ST_WRITE);
    assign busy      = (state == ST_FETCH) || (state == ST_LATCH) || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign cpu_hold  = (state != ST_DONE);
    assign checksum  = sum;

endmodule

// File: tb/tb_prom_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_prom_boot_loader
// Two copier instances: a 4-word one writing just below the top of the RAM
// address space (so its addresses wrap) and a full 512-word one. Expected
// writes are queued by the stimulus; monitors pop and compare on every
// accepted write.
// ----------------------------------------------------------------------------
module tb_prom_boot_loader;

    localparam logic [17:0] BASE4   = 18'h3FFFE;
    localparam logic [17:0] BASE512 = 18'h01000;

    typedef struct {
        logic [17:0] adr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start4, we4, ack4, busy4, done4, hold4;
    logic [8:0]  padr4;
    logic [31:0] pdata4, wdata4, sum4;
    logic [17:0] radr4;

    logic        start512, we512, ack512, busy512, done512, hold512;
    logic [8:0]  padr512;
    logic [31:0] pdata512, wdata512, sum512;
    logic [17:0] radr512;

    prom_boot_loader #(.WORDS(4), .RAM_AW(18), .DST_BASE(int'(BASE4))) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .prom_adr(padr4), .prom_data(pdata4),
        .ram_adr(radr4), .ram_wdata(wdata4), .ram_we(we4), .ram_ack(ack4),
        .busy(busy4), .done(done4), .cpu_hold(hold4), .checksum(sum4)
    );

    prom_boot_loader #(.WORDS(512), .RAM_AW(18), .DST_BASE(int'(BASE512))) dut512 (
        .clk(clk), .rst(rst), .start(start512),
        .prom_adr(padr512), .prom_data(pdata512),
        .ram_adr(radr512), .ram_wdata(wdata512), .ram_we(we512), .ram_ack(ack512),
        .busy(busy512), .done(done512), .cpu_hold(hold512), .checksum(sum512)
    );

    // PROM models with one cycle of registered read latency
    logic [31:0] prom4   [0:511];
    logic [31:0] prom512 [0:511];
    always @(posedge clk) begin
        pdata4   <= prom4[padr4];
        pdata512 <= prom512[padr512];
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    wr_t q4[$];
    wr_t q512[$];

    // Ack driver for the 4-word instance: tied high, except that a chosen
    // address can be stalled for a given number of cycles
    logic        ack_en4;
    logic [17:0] stall_adr;
    int          stall_len;
    int          stall_ctr;

    initial begin
        ack4 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (we4 && radr4 == stall_adr && stall_ctr < stall_len) begin
                ack4 = 1'b0;
                stall_ctr++;
            end else begin
                ack4 = ack_en4;
            end
        end
    end

    // Write monitor + stability check, 4-word instance
    logic        pwe4 = 1'b0, pack4 = 1'b0;
    logic [17:0] padr_h4;
    logic [31:0] pdat_h4;
    always @(negedge clk) begin
        if (!rst && we4 && ack4) begin
            if (q4.size() == 0) begin
                checks++;
                $display("FAIL wr4_unexpected: got write adr=0x%0h data=0x%0h, expected none", radr4, wdata4);
            end else begin
                wr_t e;
                e = q4.pop_front();
                chk("wr4_adr", 64'(radr4), 64'(e.adr));
                chk("wr4_data", 64'(wdata4), 64'(e.data));
            end
        end
        if (!rst && pwe4 && !pack4 && we4) begin
            chk("stall4_adr", 64'(radr4), 64'(padr_h4));
            chk("stall4_data", 64'(wdata4), 64'(pdat_h4));
        end
        pwe4    = we4 && !rst;
        pack4   = ack4;
        padr_h4 = radr4;
        pdat_h4 = wdata4;
    end

    // Write monitor, 512-word instance
    logic [17:0] last_adr512 = '0;
    int          nwr512 = 0;
    always @(negedge clk) begin
        if (!rst && we512 && ack512) begin
            nwr512++;
            last_adr512 = radr512;
            if (q512.size() == 0) begin
                checks++;
                $display("FAIL wr512_unexpected: got write adr=0x%0h, expected none", radr512);
            end else begin
                wr_t e;
                e = q512.pop_front();
                chk("wr512_adr", 64'(radr512), 64'(e.adr));
                chk("wr512_data", 64'(wdata512), 64'(e.data));
            end
        end
    end

    // One full copy on the 4-word instance. stall: word 1 acked 5 cycles late.
    // mid_start: extra start pulse while busy. exp_n: edges from start to done.
    task automatic copy4(input bit stall, input bit mid_start, input int exp_n);
        int n;
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.adr  = BASE4 + 18'(i);
            e.data = 32'h100 + 32'(i);
            q4.push_back(e);
        end
        ack_en4   = 1'b1;
        stall_adr = BASE4 + 18'd1;
        stall_len = stall ? 5 : 0;
        stall_ctr = 0;
        start4    = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("start_done", 64'(done4), 64'(0));
        chk("start_hold", 64'(hold4), 64'(1));
        chk("start_busy", 64'(busy4), 64'(1));
        n = 0;
        while (!done4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start4 = (mid_start && n == 5);
        end
        start4 = 1'b0;
        chk("done_cycles", 64'(n), 64'(exp_n));
        chk("done_flag", 64'(done4), 64'(1));
        chk("done_busy", 64'(busy4), 64'(0));
        chk("done_hold", 64'(hold4), 64'(0));
        chk("checksum4", 64'(sum4), 64'h406);
        chk("q4_empty", 64'(q4.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", 64'(done4), 64'(1));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) begin
            prom4[i]   = 32'h100 + 32'(i);
            prom512[i] = 32'hFFFF_FFFF;
        end
        rst       = 1'b1;
        start4    = 1'b0;
        start512  = 1'b0;
        ack512    = 1'b1;
        ack_en4   = 1'b0;
        stall_adr = '0;
        stall_len = 0;
        stall_ctr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset, then idle with no start
        repeat (10) @(posedge clk);
        #1;
        chk("idle_we", 64'(we4), 64'(0));
        chk("idle_busy", 64'(busy4), 64'(0));
        chk("idle_hold", 64'(hold4), 64'(1));
        chk("idle_done", 64'(done4), 64'(0));
        chk("idle_sum", 64'(sum4), 64'(0));
        chk("idle_radr", 64'(radr4), 64'(BASE4));
        chk("idle_padr", 64'(padr4), 64'(0));
        chk("idle_wdata", 64'(wdata4), 64'(0));

        // Plain copy, zero-wait ack (ack also high outside WRITE)
        copy4(1'b0, 1'b0, 12);
        // Word 1 acked 5 cycles late, restarted from DONE
        copy4(1'b1, 1'b0, 17);

        // Reset during WRITE of word 2
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.adr  = BASE4 + 18'(i);
            e.data = 32'h100 + 32'(i);
            q4.push_back(e);
        end
        ack_en4   = 1'b1;
        stall_adr = BASE4 + 18'd2;
        stall_len = 1000;
        stall_ctr = 0;
        start4    = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (!(we4 && radr4 == BASE4 + 18'd2) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("word2_write_reached", 64'(we4 && radr4 == BASE4 + 18'd2), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_we", 64'(we4), 64'(0));
        chk("rst_busy", 64'(busy4), 64'(0));
        chk("rst_done", 64'(done4), 64'(0));
        chk("rst_hold", 64'(hold4), 64'(1));
        chk("rst_sum", 64'(sum4), 64'(0));
        chk("rst_radr", 64'(radr4), 64'(BASE4));
        chk("rst_padr", 64'(padr4), 64'(0));
        chk("rst_wdata", 64'(wdata4), 64'(0));
        chk("rst_q4_left", 64'(q4.size()), 64'(2));
        q4.delete();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Recopy from word 0 with a start pulse while busy, then again from DONE
        copy4(1'b0, 1'b1, 12);
        copy4(1'b0, 1'b0, 12);

        // Full 512-word copy of all-ones words
        for (int i = 0; i < 512; i++) begin
            wr_t e;
            e.adr  = BASE512 + 18'(i);
            e.data = 32'hFFFF_FFFF;
            q512.push_back(e);
        end
        start512 = 1'b1;
        @(posedge clk);
        #1;
        start512 = 1'b0;
        n = 0;
        while (!done512 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done512_cycles", 64'(n), 64'(1536));
        chk("done512_flag", 64'(done512), 64'(1));
        chk("hold512", 64'(hold512), 64'(0));
        chk("writes512", 64'(nwr512), 64'(512));
        chk("last_adr512", 64'(last_adr512), 64'(18'h011FF));
        chk("checksum512", 64'(sum512), 64'hFFFF_FE00);
        chk("q512_empty", 64'(q512.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
